mem_arbiter: RTL and testbench

- Sits directly downstream of the I-cache and D-cache fill FSMs; upstream of the single-ported, pipelined main memory.
- Grants memory to one fill FSM for the whole duration of its line fill.
- Forwards D-cache write-through stores to memory.
- Tags every issued read so each returning memory_data_valid is routed only to the cache that issued it.

---
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined memory port between the I-cache and D-cache fill FSMs.
// A granted fill keeps the port until its read request drops; D write-through stores are
// single-cycle and go out whenever no read is being granted. Every issued read is tagged
// with its owner so the returning valid reaches only the cache that asked for it.
// Build macro ARB_RR_EN: round-robin between contending read requests (default: D over I).
module mem_arbiter #(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned LATENCY = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read_req,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              d_read_req,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic              d_wrt,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [DATA_W-1:0] mem_data_in,
   input  logic              mem_data_valid,
   output logic              mem_enable,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              i_wait,
   output logic              d_wait,
   output logic              i_data_valid,
   output logic              d_data_valid,
   output logic [DATA_W-1:0] mem_data_out,
   output logic              err
);

   typedef enum logic [1:0] {StIdle, StServeI, StServeD} state_e;

   state_e             state_q, state_d;
   logic [LATENCY-1:0] tag_vld_q;   // oldest entry at LATENCY-1
   logic [LATENCY-1:0] tag_own_q;   // 1 = D-cache owns the read
   logic               err_q, err_d;
   logic               arb_free;    // no fill holds the port this cycle
   logic               grant_i, grant_d, wr_go;
   logic               pick_d;      // winner when both read requests contend
   logic               head_vld, head_own_d;

`ifdef ARB_RR_EN
   logic last_d_q;                  // 1 = D won the most recent contest
   logic contest;
   assign pick_d  = ~last_d_q;
   assign contest = arb_free & i_read_req & d_read_req;
`else
   assign pick_d = 1'b1;
`endif

   // A serving state whose request just dropped arbitrates like IDLE in the same cycle.
   always_comb begin
      arb_free = (state_q == StIdle) ||
                 (state_q == StServeI && !i_read_req) ||
                 (state_q == StServeD && !d_read_req);
      grant_i  = 1'b0;
      grant_d  = 1'b0;
      wr_go    = 1'b0;
      state_d  = state_q;
      if (arb_free) begin
         state_d = StIdle;
         if (d_read_req && i_read_req) begin
            grant_d = pick_d;
            grant_i = ~pick_d;
         end else if (d_read_req) begin
            grant_d = 1'b1;
         end else if (d_wrt) begin
            wr_go = 1'b1;
         end else if (i_read_req) begin
            grant_i = 1'b1;
         end
         if (grant_d) state_d = StServeD;
         if (grant_i) state_d = StServeI;
      end else if (state_q == StServeI) begin
         grant_i = 1'b1;
      end else begin
         grant_d = 1'b1;
      end
   end

   assign head_vld   = tag_vld_q[LATENCY-1];
   assign head_own_d = tag_own_q[LATENCY-1];
   // A valid without a tag, or a tag without a valid, is a routing error.
   assign err_d      = err_q | (mem_data_valid ^ head_vld);

   // Drive the memory port and handshakes; everything but the data broadcast is 0 in reset.
   always_comb begin
      mem_enable   = 1'b0;
      mem_wr       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      i_wait       = 1'b0;
      d_wait       = 1'b0;
      i_data_valid = 1'b0;
      d_data_valid = 1'b0;
      if (!rst) begin
         mem_enable   = grant_i | grant_d | wr_go;
         mem_wr       = wr_go;
         if (grant_i) begin
            mem_addr = i_addr;
         end else if (grant_d || wr_go) begin
            mem_addr = d_addr;
         end
         if (wr_go) mem_wdata = d_wdata;
         i_wait       = i_read_req & ~grant_i;
         d_wait       = (d_read_req | d_wrt) & ~grant_d & ~wr_go;
         i_data_valid = mem_data_valid & head_vld & ~head_own_d;
         d_data_valid = mem_data_valid & head_vld & head_own_d;
      end
   end

   assign mem_data_out = mem_data_in;
   assign err          = err_q;

   // State, owner-tag shift register and sticky error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         tag_vld_q <= '0;
         tag_own_q <= '0;
         err_q     <= 1'b0;
`ifdef ARB_RR_EN
         last_d_q  <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         err_q        <= err_d;
         tag_vld_q[0] <= grant_i | grant_d;
         tag_own_q[0] <= grant_d;
         for (int k = 1; k < int'(LATENCY); k++) begin
            tag_vld_q[k] <= tag_vld_q[k-1];
            tag_own_q[k] <= tag_own_q[k-1];
         end
`ifdef ARB_RR_EN
         if (contest) last_d_q <= grant_d;
`endif
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a behavioural model of the arbitration rules and of
// the owner of each in-flight read, plus a fixed-latency memory that answers the DUT's reads.
`timescale 1ns/1ps
module tb_mem_arbiter;

   localparam int AW  = 16;
   localparam int DW  = 16;
   localparam int LAT = 4;
   localparam int VW  = 2 + AW + DW + 5;
   localparam int GN  = 0;
   localparam int GI  = 1;
   localparam int GD  = 2;
`ifdef ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_read_req = 1'b0, d_read_req = 1'b0, d_wrt = 1'b0;
   logic [AW-1:0] i_addr = '0, d_addr = '0;
   logic [DW-1:0] d_wdata = '0, mem_data_in = '0;
   logic          mem_data_valid = 1'b0;
   logic          mem_enable, mem_wr, i_wait, d_wait, i_data_valid, d_data_valid, err;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_data_out;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst),
      .i_read_req(i_read_req), .i_addr(i_addr),
      .d_read_req(d_read_req), .d_addr(d_addr),
      .d_wrt(d_wrt), .d_wdata(d_wdata),
      .mem_data_in(mem_data_in), .mem_data_valid(mem_data_valid),
      .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .i_wait(i_wait), .d_wait(d_wait),
      .i_data_valid(i_data_valid), .d_data_valid(d_data_valid),
      .mem_data_out(mem_data_out), .err(err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- reference model ----------------
   typedef struct {int due; bit own_d;} tag_t;
   tag_t tq[$];          // reads the model expects to be in flight, with their owner
   int   mq[$];          // due cycles of reads the memory has accepted
   int   cyc = 0;
   int   m_holder = GN;  // requester holding the port
   int   m_last = GI;    // winner of the last contest
   bit   m_err = 1'b0;
   bit   head_v = 1'b0, head_d = 1'b0;
   bit   mem_auto = 1'b1, inj_valid = 1'b0;
   bit   m_holding, exp_contest, exp_write;
   int   exp_grant;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_wdata;
   logic [VW-1:0] exp_vec, dut_vec;

   assign dut_vec = {mem_enable, mem_wr, mem_addr, mem_wdata, i_wait, d_wait,
                     i_data_valid, d_data_valid, err};

   always @* begin
      m_holding   = (m_holder == GI && i_read_req) || (m_holder == GD && d_read_req);
      exp_contest = !m_holding && i_read_req && d_read_req;
      exp_write   = 1'b0;
      exp_grant   = GN;
      if (m_holding) exp_grant = m_holder;
      else if (exp_contest) exp_grant = (RR && m_last == GD) ? GI : GD;
      else if (d_read_req) exp_grant = GD;
      else if (d_wrt) exp_write = 1'b1;
      else if (i_read_req) exp_grant = GI;
      e_addr  = (exp_grant == GI) ? i_addr : ((exp_grant == GD || exp_write) ? d_addr : '0);
      e_wdata = exp_write ? d_wdata : '0;
      if (rst) exp_vec = '0;
      else exp_vec = {exp_grant != GN || exp_write, exp_write, e_addr, e_wdata,
                      i_read_req && exp_grant != GI,
                      (d_read_req || d_wrt) && exp_grant != GD && !exp_write,
                      mem_data_valid && head_v && !head_d,
                      mem_data_valid && head_v && head_d, m_err};
   end

   always @(posedge rst) begin
      m_holder = GN; m_last = GI; m_err = 1'b0;
      tq.delete(); head_v = 1'b0; head_d = 1'b0;
   end

   always @(posedge clk) begin
      int  g;
      bit  ct;
      g  = exp_grant;
      ct = exp_contest;
      if (!rst) begin
         if (mem_data_valid !== head_v) m_err = 1'b1;
         if (g != GN) tq.push_back('{cyc + LAT, g == GD});
         if (ct) m_last = g;
         m_holder = g;
      end
      if (mem_enable === 1'b1 && mem_wr === 1'b0) mq.push_back(cyc + LAT);
      cyc++;
      while (tq.size() > 0 && tq[0].due < cyc) void'(tq.pop_front());
      head_v = tq.size() > 0 && tq[0].due == cyc;
      head_d = head_v && tq[0].own_d;
      while (mq.size() > 0 && mq[0] < cyc) void'(mq.pop_front());
      mem_data_in <= 16'($urandom);
      if (mem_auto) begin
         if (mq.size() > 0 && mq[0] == cyc) begin
            void'(mq.pop_front());
            mem_data_valid <= 1'b1;
         end else begin
            mem_data_valid <= 1'b0;
         end
      end else begin
         mem_data_valid <= inj_valid;
      end
   end

   // ---------------- helpers (stimulus only) ----------------
   task automatic idle_inputs();
      i_read_req = 1'b0; d_read_req = 1'b0; d_wrt = 1'b0;
   endtask

   task automatic do_reset(input bit mem_too);
      idle_inputs();
      rst = 1'b1;
      if (mem_too) mq.delete();
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      i_read_req = 1'b1; d_read_req = 1'b1; d_wrt = 1'b1;
      i_addr = 16'h1111; d_addr = 16'h2222; d_wdata = 16'h3333;
      @(negedge clk);
      checks++;
      if (dut_vec !== '0) begin
         errors++; $display("FAIL reset_outputs got %h exp 0", dut_vec);
      end
      checks++;
      if (mem_data_out !== mem_data_in) begin
         errors++; $display("FAIL reset_passthru got %h exp %h", mem_data_out, mem_data_in);
      end
      @(posedge clk); #1;
      idle_inputs();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec || err !== 1'b0) begin
         errors++; $display("FAIL reset_release got %h exp %h", dut_vec, exp_vec);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_i_alone();
      int nv_i = 0, nv_d = 0;
      for (int k = 0; k < 14; k++) begin
         i_read_req = (k < 8);
         i_addr = 16'h1230;
         @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec) begin
            errors++; $display("FAIL i_alone_vec k=%0d got %h exp %h", k, dut_vec, exp_vec);
         end
         checks++;
         if (i_data_valid !== (k >= 4 && k < 12)) begin
            errors++; $display("FAIL i_alone_valid k=%0d got %b", k, i_data_valid);
         end
         if (k == 0) begin
            checks++;
            if (mem_enable !== 1'b1 || i_wait !== 1'b0 || mem_addr !== 16'h1230) begin
               errors++;
               $display("FAIL i_alone_grant got en=%b wait=%b addr=%h exp 1 0 1230",
                        mem_enable, i_wait, mem_addr);
            end
         end
         nv_i += int'(i_data_valid);
         nv_d += int'(d_data_valid);
         @(posedge clk); #1;
      end
      checks++;
      if (nv_i != 8 || nv_d != 0 || err !== 1'b0) begin
         errors++; $display("FAIL i_alone_count got i=%0d d=%0d err=%b exp 8 0 0", nv_i, nv_d, err);
      end
   endtask

   // Both requests rise together; winner holds 5 cycles, loser 11.
   task automatic test_contend(input bit d_first);
      logic w_v, l_v, l_wait;
      logic [AW-1:0] w_addr, l_addr;
      for (int k = 0; k < 16; k++) begin
         d_read_req = d_first ? (k < 5) : (k < 11);
         i_read_req = d_first ? (k < 11) : (k < 5);
         d_addr = 16'h4000 | 16'(k);
         i_addr = 16'h1000 | 16'(k);
         @(negedge clk);
         w_v    = d_first ? d_data_valid : i_data_valid;
         l_v    = d_first ? i_data_valid : d_data_valid;
         l_wait = d_first ? i_wait : d_wait;
         w_addr = d_first ? d_addr : i_addr;
         l_addr = d_first ? i_addr : d_addr;
         checks++;
         if (dut_vec !== exp_vec) begin
            errors++; $display("FAIL contend_vec k=%0d got %h exp %h", k, dut_vec, exp_vec);
         end
         checks++;
         if (w_v !== (k >= 4 && k <= 8) || l_v !== (k >= 9 && k <= 14)) begin
            errors++; $display("FAIL contend_route k=%0d got win=%b lose=%b", k, w_v, l_v);
         end
         checks++;
         if (l_wait !== (k < 5)) begin
            errors++; $display("FAIL contend_wait k=%0d got %b exp %b", k, l_wait, k < 5);
         end
         if (k < 11) begin
            checks++;
            if (mem_enable !== 1'b1 || mem_addr !== (k < 5 ? w_addr : l_addr)) begin
               errors++; $display("FAIL contend_addr k=%0d got %h", k, mem_addr);
            end
         end
         @(posedge clk); #1;
      end
      idle_inputs();
   endtask

   task automatic test_write_during_i();
      for (int k = 0; k < 11; k++) begin
         i_read_req = (k < 4);
         i_addr = 16'h2000;
         if (k == 1) begin
            d_wrt = 1'b1; d_addr = 16'h00F0; d_wdata = 16'hBEEF;
         end
         if (k == 5) d_wrt = 1'b0;
         @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec) begin
            errors++; $display("FAIL wr_vec k=%0d got %h exp %h", k, dut_vec, exp_vec);
         end
         if (k >= 1 && k <= 3) begin
            checks++;
            if (d_wait !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 16'h2000) begin
               errors++; $display("FAIL wr_held k=%0d got wait=%b wr=%b", k, d_wait, mem_wr);
            end
         end
         if (k == 4) begin
            checks++;
            if (mem_enable !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 16'h00F0 ||
                mem_wdata !== 16'hBEEF || d_wait !== 1'b0) begin
               errors++;
               $display("FAIL wr_issue got en=%b wr=%b addr=%h data=%h exp 1 1 00f0 beef",
                        mem_enable, mem_wr, mem_addr, mem_wdata);
            end
         end
         checks++;
         if (i_data_valid !== (k >= 4 && k <= 7) || d_data_valid !== 1'b0) begin
            errors++; $display("FAIL wr_route k=%0d got i=%b d=%b", k, i_data_valid, d_data_valid);
         end
         @(posedge clk); #1;
      end
      checks++;
      if (err !== 1'b0) begin
         errors++; $display("FAIL wr_no_tag got err=%b exp 0", err);
      end
   endtask

   task automatic test_err_inject();
      mem_auto = 1'b0;
      for (int k = 0; k < 9; k++) begin
         inj_valid = (k == 0);
         @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec) begin
            errors++; $display("FAIL err_vec k=%0d got %h exp %h", k, dut_vec, exp_vec);
         end
         checks++;
         if (err !== (k >= 2) || i_data_valid !== 1'b0 || d_data_valid !== 1'b0) begin
            errors++; $display("FAIL err_sticky k=%0d got err=%b i=%b d=%b", k, err,
                               i_data_valid, d_data_valid);
         end
         @(posedge clk); #1;
      end
      mem_auto = 1'b1;
      do_reset(1'b1);
      @(negedge clk);
      checks++;
      if (err !== 1'b0) begin
         errors++; $display("FAIL err_clear got %b exp 0", err);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_midfill();
      for (int k = 0; k < 3; k++) begin
         i_read_req = 1'b1;
         i_addr = 16'h3000 | 16'(k);
         @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec) begin
            errors++; $display("FAIL midfill_vec k=%0d got %h exp %h", k, dut_vec, exp_vec);
         end
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      checks++;
      if (dut_vec !== '0) begin
         errors++; $display("FAIL midfill_reset got %h exp 0", dut_vec);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      idle_inputs();
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec || i_data_valid !== 1'b0) begin
            errors++; $display("FAIL midfill_drop k=%0d got %h exp %h", k, dut_vec, exp_vec);
         end
         @(posedge clk); #1;
      end
      checks++;
      if (err !== 1'b1) begin
         errors++; $display("FAIL midfill_err got %b exp 1", err);
      end
      do_reset(1'b1);
   endtask

   task automatic test_random();
      for (int k = 0; k < 420; k++) begin
         if (k < 400) begin
            if ($urandom_range(3) == 0) i_read_req = ~i_read_req;
            if ($urandom_range(3) == 0) d_read_req = ~d_read_req;
            d_wrt   = ($urandom_range(2) == 0);
            i_addr  = 16'($urandom);
            d_addr  = 16'($urandom);
            d_wdata = 16'($urandom);
         end else begin
            idle_inputs();
         end
         @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec) begin
            errors++; $display("FAIL random_vec k=%0d got %h exp %h", k, dut_vec, exp_vec);
         end
         checks++;
         if (mem_data_out !== mem_data_in) begin
            errors++; $display("FAIL random_passthru k=%0d got %h exp %h", k, mem_data_out,
                               mem_data_in);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_i_alone();
      do_reset(1'b1);
      test_contend(1'b1);
      test_contend(!RR);
      test_write_during_i();
      test_err_inject();
      test_reset_midfill();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
